// File: rtl/switch_allocator.sv
// Packet-locked round-robin switch allocator, 5-port mesh router.
// Optional watchdog release: define SA_TIMEOUT_EN.
module switch_allocator #(
  parameter int NUM_PORTS      = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_PORTS-1:0]     req_valid_i,
  input  logic [3*NUM_PORTS-1:0]   req_port_i,
  input  logic [2*NUM_PORTS-1:0]   req_type_i,
  input  logic [NUM_PORTS-1:0]     out_ready_i,
  output logic [NUM_PORTS-1:0]     grant_o,
  output logic [3*NUM_PORTS-1:0]   out_sel_o,
  output logic [NUM_PORTS-1:0]     out_valid_o,
  output logic [NUM_PORTS-1:0]     out_busy_o,
  output logic                     timeout_o
);

  localparam logic [2:0] NONE_PORT = 3'(NUM_PORTS);
  localparam logic [1:0] T_HEAD = 2'd0;
  localparam logic [1:0] T_TAIL = 2'd1;
  localparam logic [1:0] T_BODY = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_t;

  state_t     r_state [NUM_PORTS];
  logic [2:0] r_owner [NUM_PORTS];
  logic [2:0] r_rr    [NUM_PORTS];

  logic [NUM_PORTS-1:0] w_gnt_in;
  logic [NUM_PORTS-1:0] w_gnt_out;
  logic [NUM_PORTS-1:0] w_head_gnt;
  logic [NUM_PORTS-1:0] w_tail_gnt;
  logic [NUM_PORTS-1:0] w_expire;
  logic [2:0]           w_win [NUM_PORTS];
  logic [2:0]           w_sel [NUM_PORTS];
  logic                 w_found;
  int                   w_idx;
  logic [1:0]           w_typ;

  // Per-output arbitration: RR head pick when idle, owner-only when locked
  always_comb begin
    w_gnt_in   = '0;
    w_gnt_out  = '0;
    w_head_gnt = '0;
    w_tail_gnt = '0;
    w_found    = 1'b0;
    w_idx      = 0;
    w_typ      = 2'd3;
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_win[o] = NONE_PORT;
      w_sel[o] = NONE_PORT;
      w_found  = 1'b0;
      if (r_state[o] == S_IDLE) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          w_idx = int'(r_rr[o]) + k;
          if (w_idx >= NUM_PORTS) w_idx = w_idx - NUM_PORTS;
          if (!w_found && req_valid_i[w_idx] &&
              req_port_i[3*w_idx +: 3] == 3'(o) &&
              req_type_i[2*w_idx +: 2] == T_HEAD) begin
            w_found  = 1'b1;
            w_win[o] = 3'(w_idx);
          end
        end
        if (w_found && out_ready_i[o]) begin
          w_head_gnt[o]        = 1'b1;
          w_gnt_out[o]         = 1'b1;
          w_gnt_in[w_win[o]]   = 1'b1;
          w_sel[o]             = w_win[o];
        end
      end else begin
        w_sel[o] = r_owner[o];
        w_idx    = int'(r_owner[o]);
        if (w_idx < NUM_PORTS) begin
          w_typ = req_type_i[2*w_idx +: 2];
          if (out_ready_i[o] && req_valid_i[w_idx] &&
              req_port_i[3*w_idx +: 3] == 3'(o) &&
              (w_typ == T_BODY || w_typ == T_TAIL)) begin
            w_gnt_out[o]    = 1'b1;
            w_gnt_in[w_idx] = 1'b1;
            w_tail_gnt[o]   = (w_typ == T_TAIL);
          end
        end
      end
    end
  end

  // Lock state, owner and round-robin pointer per output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        r_state[o] <= S_IDLE;
        r_owner[o] <= NONE_PORT;
        r_rr[o]    <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_head_gnt[o]) begin
          r_state[o] <= S_ACTIVE;
          r_owner[o] <= w_win[o];
          r_rr[o]    <= (w_win[o] == 3'(NUM_PORTS-1)) ?
                        3'd0 : w_win[o] + 3'd1;
        end else if (w_tail_gnt[o] || w_expire[o]) begin
          r_state[o] <= S_IDLE;
          r_owner[o] <= NONE_PORT;
        end
      end
    end
  end

`ifdef SA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt [NUM_PORTS];
  logic          r_timeout;

  // A locked output that stalls TIMEOUT_CYCLES in a row is released
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      w_expire[o] = (r_state[o] == S_ACTIVE) && !w_gnt_out[o] &&
                    (r_cnt[o] == CW'(TIMEOUT_CYCLES - 1));
    end
  end

  // Stall counters and the merged one-cycle release pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_PORTS; o++) r_cnt[o] <= '0;
      r_timeout <= 1'b0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (w_gnt_out[o] || w_expire[o]) begin
          r_cnt[o] <= '0;
        end else if (r_state[o] == S_ACTIVE) begin
          r_cnt[o] <= r_cnt[o] + 1'b1;
        end
      end
      r_timeout <= |w_expire;
    end
  end

  assign timeout_o = r_timeout;
`else
  assign w_expire  = '0;
  assign timeout_o = 1'b0;
`endif

  // Outputs are forced to idle values while reset is held
  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_sel_o[3*o +: 3] = rst_n ? w_sel[o] : NONE_PORT;
      out_busy_o[o]       = (r_state[o] == S_ACTIVE);
    end
  end

  assign grant_o     = rst_n ? w_gnt_in  : '0;
  assign out_valid_o = rst_n ? w_gnt_out : '0;

endmodule
